mips_cpu_bus_lsu: RTL and testbench
===================================

# mips_cpu_bus_lsu

Bus initiator for the CPU's load/store path. It accepts one byte, halfword or word access at a time from the core and runs it as a single Avalon-style transaction with `read`/`write`, `byteenable` and `waitrequest`. On reads it extracts and extends the addressed lane from `readdata`, then returns one response per request. It sits between the core datapath and `mips_cpu_bus_memory` or any other responder on the same bus.

## Interface
- `ADDR_W`, 32: byte-address width of the core request and of the bus `address`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: the LSU can accept a request. High only in IDLE.
- `req_write` in 1: 1 for store, 0 for load.
- `req_size` in 2: 0 for byte, 1 for half, 2 for word. Value 3 is illegal and is treated as misaligned.
- `req_signed` in 1: sign-extend loaded data. Ignored for word accesses and stores.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle response pulse. There is no backpressure on responses.
- `resp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal request, qualified by `resp_valid`.
- `address` out `ADDR_W`: word-aligned bus address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `byteenable` out 4: active lanes; lane n is bits [8n+7:8n], little-endian.
- `writedata` out 32: lane-steered store data.
- `waitrequest` in 1: the responder stalls the current command.
- `readdata` in 32: valid exactly one cycle after a read is accepted.

## Operation
- **Alignment.** A half access with `addr[0]=1`, a word access with `addr[1:0]≠0`, or `size=3` is an error. An error issues no bus activity.
- **Byteenable.**
  - byte: `0001<<addr[1:0]`
  - half: `0011` if `addr[1]=0`, otherwise `1100`
  - word: `1111`
- **Writedata.**
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- **Read extraction.** Select the lane(s) given by `addr[1:0]`, then zero- or sign-extend according to `req_signed`.
- **FSM states:** IDLE, CMD, RDATA, RESP.
  - **IDLE.** `req_ready=1`. On `req_valid`, latch all request fields.
    - Misaligned or illegal request: go to RESP with `err=1`.
    - Otherwise: go to CMD.
  - **CMD.**
    - Drive `read` or `write`, plus `address`, `byteenable` and `writedata`, all from latched values and held stable.
    - While `waitrequest=1`, stay in CMD.
    - When `waitrequest=0`: a store goes to RESP; a load goes to RDATA.
  - **RDATA.** Strobes are low. Capture `readdata`, extract and extend it into the response register, then go to RESP.
  - **RESP.** `resp_valid=1` for exactly one cycle, then go to IDLE.
- `read` and `write` are never high together and are only ever high in CMD.
- A `req_valid` seen outside IDLE is ignored. The core must hold the request until it sees `req_ready`.

## Timing
- **Reset values:**
  - `req_ready=1`
  - `read`, `write`, `resp_valid`, `resp_err` = 0
  - `byteenable=0`
  - `address`, `writedata`, `resp_rdata` = 0
  - state = IDLE
- **Store latency** (request accepted at cycle 0): `write` is high in cycle 1, and `resp_valid` is high in cycle 2 plus the number of `waitrequest` stall cycles.
- **Load latency** (request accepted at cycle 0): `read` is high in cycle 1, `readdata` is sampled in cycle 2, and `resp_valid` is high in cycle 3 plus the number of stall cycles.
- **Error latency:** `resp_valid` is high in cycle 1.
- **Throughput:** one new request is accepted in the cycle after RESP. The minimum is 3 cycles per store and 4 per load.
- **Reset mid-operation:** reset in any state forces IDLE on the next edge and drops the strobes, even if `waitrequest=1`. The transaction is abandoned and no response is generated.
- All outputs are registered. There is no combinational path from `waitrequest` or `readdata` to any output.

## Structure
- **Package `mips_cpu_bus_pkg`** holds the shared typedefs and constants:
  - `lsu_size_t` enum: BYTE, HALF, WORD
  - `lsu_state_t` enum: IDLE, CMD, RDATA, RESP
  - `BE_*` lane constants
- **Sub-module `mips_cpu_bus_lane`** is combinational and holds all lane steering:
  - alignment check
  - `byteenable` generation
  - `writedata` replication
  - read lane extraction and extension

  The top level holds only the FSM and registers.

## Test plan
- **Word store:** `addr=0x100`, data `0xDEADBEEF`, `waitrequest=0`. Expect `write=1` in cycle 1 with `address=0x100`, `byteenable=1111`, `writedata=0xDEADBEEF`. Expect `resp_valid` in cycle 2 with `err=0` and `rdata=0`.
- **Signed byte load:** `addr=0x103`, responder `readdata=0x80112233`. Expect `byteenable=1000` and `resp_rdata=0xFFFFFF80`. Repeat unsigned and expect `0x00000080`.
- **Half store with stalls:** `addr=0x202`, data `0x0000ABCD`, `waitrequest` high for 3 cycles. Expect `byteenable=1100`, `writedata=0xABCDABCD`, all command signals held stable for 4 cycles, and `resp_valid` in cycle 5.
- **Misaligned word load:** `addr=0x101`. Expect no `read` strobe, and in cycle 1 `resp_valid=1`, `resp_err=1`, `resp_rdata=0`. Repeat with `size=3` and expect the same result.
- **Reset during stalled read:** assert `reset` for 1 cycle while in CMD with `waitrequest=1`. Expect `read=0` and `req_ready=1` on the next edge, and no `resp_valid`. A following load then completes normally.
- **Back-to-back requests:** hold `req_valid` continuously for two loads. Expect the second to be accepted only after the first `resp_valid`, with no overlap of strobes.

Source files
------------

// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg
// Shared types and constants for the CPU load/store bus initiator:
//   lsu_size_t  - access size encoding carried on req_size (3 is illegal)
//   lsu_state_t - LSU controller states
//   BE_*        - byteenable lane patterns (lane n = bits [8n+7:8n])
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_lane.sv
// mips_cpu_bus_lane
// Purely combinational lane steering for the load/store unit.
// Command side (from the live core request):
//   size, addr_lo, wdata   -> misaligned, byteenable, wdata_lanes
// Read side (from the latched request and the bus):
//   rd_size, rd_lo, rd_signed, rdata -> rdata_ext
module mips_cpu_bus_lane
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        misaligned,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lanes,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_lo,
  input  logic        rd_signed,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    misaligned  = 1'b0;
    byteenable  = BE_NONE;
    wdata_lanes = wdata;
    case (size)
      BYTE: begin
        byteenable  = BE_B0 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      HALF: begin
        misaligned  = addr_lo[0];
        byteenable  = addr_lo[1] ? BE_HI : BE_LO;
        wdata_lanes = {2{wdata[15:0]}};
      end
      WORD: begin
        misaligned  = |addr_lo;
        byteenable  = BE_ALL;
      end
      // size 3 has no encoding; report it through the alignment error path
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte = rdata[7:0];
    case (rd_lo)
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      2'd3:    rd_byte = rdata[31:24];
      default: rd_byte = rdata[7:0];
    endcase
    rd_half = rd_lo[1] ? rdata[31:16] : rdata[15:0];

    case (rd_size)
      BYTE:    rdata_ext = {{24{rd_signed & rd_byte[7]}}, rd_byte};
      HALF:    rdata_ext = {{16{rd_signed & rd_half[15]}}, rd_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// mips_cpu_bus_lsu
// Load/store bus initiator: one core access at a time, run as a single
// Avalon-style read or write with byteenable and waitrequest.
// Core side : req_valid/req_ready handshake, req_write, req_size, req_signed,
//             req_addr, req_wdata; resp_valid pulse with resp_rdata, resp_err.
// Bus side  : address (word aligned), read, write, byteenable, writedata,
//             waitrequest, readdata (valid one cycle after a read is accepted).
// Every output comes straight from a flop; waitrequest/readdata only reach
// next-state logic.
module mips_cpu_bus_lsu
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  lsu_state_t        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              signed_q, signed_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       writedata_q, writedata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              cmd_misaligned;
  logic [3:0]        cmd_be;
  logic [31:0]       cmd_wdata;
  logic [31:0]       rd_ext;

  mips_cpu_bus_lane u_lane (
    .size        (req_size),
    .addr_lo     (req_addr[1:0]),
    .wdata       (req_wdata),
    .misaligned  (cmd_misaligned),
    .byteenable  (cmd_be),
    .wdata_lanes (cmd_wdata),
    .rd_size     (size_q),
    .rd_lo       (lo_q),
    .rd_signed   (signed_q),
    .rdata       (readdata),
    .rdata_ext   (rd_ext)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    lo_d         = lo_q;
    signed_d     = signed_q;
    is_write_d   = is_write_q;
    address_d    = address_q;
    be_d         = be_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d     = req_size;
          lo_d       = req_addr[1:0];
          signed_d   = req_signed;
          is_write_d = req_write;
          if (cmd_misaligned) begin
            // error short-circuits straight to the response, bus untouched
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = CMD;
            address_d   = {req_addr[ADDR_W-1:2], 2'b00};
            be_d        = cmd_be;
            writedata_d = cmd_wdata;
            read_d      = ~req_write;
            write_d     = req_write;
          end
        end
      end
      CMD: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (is_write_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = rd_ext;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: bus-side data registers are reset too, since they drive outputs directly.
      state_q      <= IDLE;
      size_q       <= '0;
      lo_q         <= '0;
      signed_q     <= 1'b0;
      is_write_q   <= 1'b0;
      address_q    <= '0;
      be_q         <= BE_NONE;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      lo_q         <= lo_d;
      signed_q     <= signed_d;
      is_write_q   <= is_write_d;
      address_q    <= address_d;
      be_q         <= be_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// tb_mips_cpu_bus_lsu
// Directed scenarios for the load/store bus initiator. Each scenario task
// drives the core and plays the bus responder cycle by cycle, checking
// strobes, command fields and response timing inline; response contents are
// checked by a scoreboard queue filled when a request is issued.
module tb_mips_cpu_bus_lsu;

  localparam int ADDR_W = 32;
  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest = 1'b0;
  logic [31:0]       readdata = JUNK;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];
  resp_t exp_e;
  int    chk_cnt  = 0;
  int    pass_cnt = 0;

  mips_cpu_bus_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_resp: got resp_valid=1 err=%b rdata=%h, required no response",
                 resp_err, resp_rdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({resp_err, resp_rdata} !== {exp_e.err, exp_e.rdata})
          $display("FAIL resp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                   resp_err, resp_rdata, exp_e.err, exp_e.rdata);
        else
          pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request from an idle LSU: request presented in cycle 0, command held
  // for stalls+1 cycles, response expected in cycle 1 (error), 2+stalls
  // (store) or 3+stalls (load).
  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int stalls,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic exp_err, input logic [31:0] exp_rdata);
    int    resp_cyc;
    logic  in_cmd;
    resp_t r;
    resp_cyc = exp_err ? 1 : (wr ? 2 + stalls : 3 + stalls);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; waitrequest = (stalls > 0); readdata = JUNK;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL %s_ready: got %b required 1", name, req_ready);
    else
      pass_cnt++;
    r.err = exp_err; r.rdata = exp_rdata;
    exp_q.push_back(r);
    for (int c = 1; c <= resp_cyc; c++) begin
      @(posedge clk); #1;
      req_valid   = 1'b0;
      waitrequest = !exp_err && (c <= stalls);
      readdata    = (!wr && !exp_err && c == stalls + 2) ? rd : JUNK;
      @(negedge clk);
      in_cmd = !exp_err && (c <= stalls + 1);
      chk_cnt++;
      if ({read, write} !== (in_cmd ? {~wr, wr} : 2'b00))
        $display("FAIL %s_strobes_c%0d: got read=%b write=%b, required cmd=%b wr=%b",
                 name, c, read, write, in_cmd, wr);
      else
        pass_cnt++;
      if (in_cmd) begin
        chk_cnt++;
        if ({address, byteenable, writedata} !== {a & 32'hFFFF_FFFC, exp_be, exp_wd})
          $display("FAIL %s_cmd_c%0d: got addr=%h be=%b wd=%h, required addr=%h be=%b wd=%h",
                   name, c, address, byteenable, writedata, a & 32'hFFFF_FFFC, exp_be, exp_wd);
        else
          pass_cnt++;
      end
      chk_cnt++;
      if (resp_valid !== (c == resp_cyc))
        $display("FAIL %s_resp_timing_c%0d: got resp_valid=%b required %b",
                 name, c, resp_valid, (c == resp_cyc));
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({req_ready, read, write, resp_valid, resp_err, byteenable, address, writedata, resp_rdata}
        !== {1'b1, 4'b0000, 4'b0000, 96'h0})
      $display("FAIL reset_values: got ready=%b rd=%b wr=%b rv=%b err=%b be=%b addr=%h wd=%h rdata=%h",
               req_ready, read, write, resp_valid, resp_err, byteenable, address, writedata, resp_rdata);
    else
      pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_store();
    do_req("word_store", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, JUNK, 0,
           4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
    do_req("byte_store", 1'b1, 2'd0, 1'b0, 32'h101, 32'h1234_565A, JUNK, 0,
           4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0);
    do_req("half_store_stall", 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, JUNK, 3,
           4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
  endtask

  task automatic test_load();
    do_req("byte_load_s", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8011_2233, 0,
           4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);
    do_req("byte_load_u", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8011_2233, 0,
           4'b1000, 32'h0, 1'b0, 32'h0000_0080);
    do_req("half_load_s", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8011_2233, 1,
           4'b1100, 32'h0, 1'b0, 32'hFFFF_8011);
    do_req("half_load_u", 1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h8011_A233, 0,
           4'b0011, 32'h0, 1'b0, 32'h0000_A233);
    do_req("word_load", 1'b0, 2'd2, 1'b1, 32'h104, 32'h0, 32'h8000_0001, 0,
           4'b1111, 32'h0, 1'b0, 32'h8000_0001);
  endtask

  task automatic test_error();
    do_req("misaligned_word", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, JUNK, 0,
           4'b0000, 32'h0, 1'b1, 32'h0);
    do_req("illegal_size", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, JUNK, 0,
           4'b0000, 32'h0, 1'b1, 32'h0);
    do_req("misaligned_half", 1'b1, 2'd1, 1'b0, 32'h105, 32'h1234, JUNK, 0,
           4'b0000, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h400; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (read !== 1'b1) $display("FAIL rst_mid_read_before: got %b required 1", read);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({read, write, req_ready, resp_valid} !== 4'b0010)
      $display("FAIL rst_mid_after: got rd=%b wr=%b ready=%b rv=%b required 0 0 1 0",
               read, write, req_ready, resp_valid);
    else
      pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if ({read, resp_valid} !== 2'b00)
        $display("FAIL rst_mid_quiet: got rd=%b rv=%b required 0 0", read, resp_valid);
      else
        pass_cnt++;
    end
    waitrequest = 1'b0;
    do_req("load_after_reset", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0BAD_F00D, 0,
           4'b1111, 32'h0, 1'b0, 32'h0BAD_F00D);
  endtask

  // Two loads with req_valid held high throughout: A accepted in cycle 0,
  // B only in cycle 4 (the cycle after A's response).
  task automatic test_back_to_back();
    resp_t r;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; waitrequest = 1'b0; readdata = JUNK;
    r.err = 1'b0; r.rdata = 32'h1111_2222; exp_q.push_back(r);
    r.err = 1'b0; r.rdata = 32'h3333_4444; exp_q.push_back(r);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) req_addr = 32'h304;
        if (c == 5) req_valid = 1'b0;
        readdata = (c == 2) ? 32'h1111_2222 : (c == 6) ? 32'h3333_4444 : JUNK;
      end
      @(negedge clk);
      chk_cnt++;
      if ({req_ready, read, write, resp_valid} !==
          {(c == 0 || c == 4 || c == 8), (c == 1 || c == 5), 1'b0, (c == 3 || c == 7)})
        $display("FAIL b2b_c%0d: got ready=%b rd=%b wr=%b rv=%b", c, req_ready, read, write, resp_valid);
      else
        pass_cnt++;
      if (c == 5) begin
        chk_cnt++;
        if (address !== 32'h304)
          $display("FAIL b2b_addr: got %h required %h", address, 32'h304);
        else
          pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_error();
    test_reset_mid_op();
    test_back_to_back();
    repeat (2) @(posedge clk);
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending responses required 0", exp_q.size());
    else
      pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
